compare_channel_scheduler: RTL and testbench
============================================

// Module: compare_channel_scheduler
// PURPOSE
// Time-multiplexes one registered magnitude comparator across CHANNELS angle-compare channels.
// Each channel holds a compare value and an arm state. A round-robin pointer presents one channel per cycle.
// The channel's value is compared against the running angle counter, and the channel raises a one-cycle event when reached.
// The block sits between the angle counter (cnt/cnt_ovf) and the ignition/injection output logic.
// PARAMETERS
// WIDTH     8  width of angle counter and compare values
// CHANNELS  4  number of compare channels (>=2)
// CW        2  channel index width, = $clog2(CHANNELS)
// PORTS
// clk        in   1         single clock, all logic on rising edge
// srst       in   1         synchronous reset, active-high
// ena        in   1         scan enable; low freezes pointer and pipeline
// cnt        in   WIDTH     running angle counter, increments, wraps to 0
// cnt_ovf    in   1         high in the cycle cnt shows its first post-wrap value
// wr         in   1         channel write strobe
// wr_ch      in   CW        channel index for write
// wr_val     in   WIDTH     compare value to load
// wr_arm     in   1         1: load value and arm, 0: disarm (value kept)
// event      out  CHANNELS  one-hot one-cycle pulse, channel reached
// event_ch   out  CW        index of the firing channel; valid while |event
// armed      out  CHANNELS  per channel: 1 = WAIT_WRAP or WAIT_HIT
// BEHAVIOUR
// - Reset (srst=1 at edge): all channels IDLE, values 0, ptr 0, stage invalid, event=0, event_ch=0, armed=0. Reset overrides wr and mid-scan state.
// - Channel states: IDLE, WAIT_WRAP (armed, must see a wrap first), WAIT_HIT (armed, fires at cnt>=val).
// - Write, wr=1, wr_arm=1: val[wr_ch]<=wr_val. State becomes WAIT_WRAP if cnt>=wr_val at that cycle, else WAIT_HIT. Equality counts as already passed.
// - Write, wr=1, wr_arm=0: state becomes IDLE.
// - A write always overrides an in-flight result for that channel.
// - cnt_ovf=1: every WAIT_WRAP channel moves to WAIT_HIT, except a channel written that same cycle, whose state comes from the write rule using the post-wrap cnt.
// - cnt_ovf and all writes act regardless of ena.
// - Scan pipeline, when ena=1:
//   - Cycle T: stage<={ptr, val[ptr], valid=1}; ptr<=ptr+1, wrapping CHANNELS-1 -> 0.
//   - Cycle T+1: comparator evaluates cnt(T+1) >= stage.val. Hit requires stage.valid, channel state WAIT_HIT, and no write to stage.ch in T or T+1 (else stage.valid<=0).
//   - Edge ending T+1: on hit, event[stage.ch]<=1, event_ch<=stage.ch, and channel -> IDLE. Otherwise event<=0.
// - Latency: channel scanned at T fires visible in cycle T+2. A hit is detected at worst CHANNELS+1 cycles after cnt reaches val.
// - At most one event bit set per cycle; event_ch holds its last value while event=0.
// - ena=0: ptr and stage hold; no compare is committed; event<=0. On resume the held stage is evaluated first.
// - Comparison is unsigned, full WIDTH, no modular arithmetic. Wrap handling is solely via WAIT_WRAP and cnt_ovf.
// - A channel fires at most once per arm. Re-arm requires a new write.
// - armed is combinational from the state registers and updates the cycle after a write.
// TESTING (WIDTH=8, CHANNELS=4)
// - Reset: drive srst mid-scan with ch1 armed -> next cycle armed=0000, event=0, ptr=0. A later cnt sweep produces no events.
// - Basic hit: cnt=10, arm ch2 val=20. Step cnt by 1 per 4 cycles -> single event=0100, event_ch=2, within 5 cycles of cnt=20. armed[2] clears on the same edge.
// - Wrap wait: cnt=200, arm ch0 val=50 -> armed=0001, no event at cnt 200..255. After cnt_ovf (cnt=0), event on ch0 after cnt reaches 50.
// - Equality at arm: cnt=77, arm ch3 val=77 -> no event until after cnt_ovf, then an event at cnt>=77.
// - Collision: ch1 in stage with a hit pending, and wr to ch1 with wr_arm=0 in the same cycle -> no event, armed[1]=0. Same with wr_arm=1, val=cnt+30 -> no event now, re-armed WAIT_HIT.
// - Multi-hit + ena: arm ch0..3 all val=5, cnt jumps to 9 -> events on 4 consecutive cycles, one-hot, in ptr order. Dropping ena for 3 cycles mid-burst -> event=0 while low, remaining channels fire after resume.

Source files
------------

// File: rtl/compare_channel_scheduler.sv
// compare_channel_scheduler
//   Shares one registered magnitude comparator across CHANNELS angle-compare
//   channels. A round-robin pointer loads one channel per cycle into a single
//   compare stage; the next cycle compares that value against the live angle
//   counter and, on a hit, raises a one-cycle event for that channel.
//
// Ports
//   clk       rising-edge clock
//   srst      synchronous reset, active-high
//   ena       scan enable; low freezes pointer and compare stage
//   cnt       running angle counter (increments, wraps to 0)
//   cnt_ovf   high in the cycle cnt shows its first post-wrap value
//   wr        channel write strobe
//   wr_ch     channel index for the write
//   wr_val    compare value to load
//   wr_arm    1: load value and arm, 0: disarm (value kept)
//   evt       one-hot, one-cycle "channel reached" pulse
//             (named evt because event is a reserved word)
//   event_ch  index of the firing channel, held while evt is zero
//   armed     per channel: waiting for wrap or waiting for hit

// Per-channel arm state and compare value.
module compare_channel_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_sel,
    input  logic             wr_arm,
    input  logic [WIDTH-1:0] wr_val,
    input  logic [WIDTH-1:0] cnt,
    input  logic             cnt_ovf,
    input  logic             hit_sel,
    output logic [WIDTH-1:0] val,
    output logic             armed,
    output logic             wait_hit
);
    typedef enum logic [1:0] {IDLE, WAIT_WRAP, WAIT_HIT} state_t;

    state_t state, state_nx;

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
            val   <= '0;
        end else begin
            state <= state_nx;
            if (wr_sel && wr_arm)
                val <= wr_val;
        end
    end

    // A write wins over wrap and hit. Arming at or past the target means the
    // angle has already been passed this revolution, so wait for a wrap.
    always_comb begin
        state_nx = state;
        if (wr_sel) begin
            if (!wr_arm)
                state_nx = IDLE;
            else if (cnt >= wr_val)
                state_nx = WAIT_WRAP;
            else
                state_nx = WAIT_HIT;
        end else if (cnt_ovf && state == WAIT_WRAP) begin
            state_nx = WAIT_HIT;
        end else if (hit_sel) begin
            state_nx = IDLE;
        end
    end

    assign armed    = (state != IDLE);
    assign wait_hit = (state == WAIT_HIT);
endmodule

module compare_channel_scheduler #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CW       = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                ena,
    input  logic [WIDTH-1:0]    cnt,
    input  logic                cnt_ovf,
    input  logic                wr,
    input  logic [CW-1:0]       wr_ch,
    input  logic [WIDTH-1:0]    wr_val,
    input  logic                wr_arm,
    output logic [CHANNELS-1:0] evt,
    output logic [CW-1:0]       event_ch,
    output logic [CHANNELS-1:0] armed
);
    typedef struct packed {
        logic             vld;
        logic [CW-1:0]    ch;
        logic [WIDTH-1:0] val;
    } stage_t;

    logic [CHANNELS-1:0][WIDTH-1:0] vals;
    logic [CHANNELS-1:0]            wait_hit;
    logic [CHANNELS-1:0]            wr_sel;
    logic [CHANNELS-1:0]            hit_sel;
    logic [CW-1:0]                  ptr;
    stage_t                         stage;
    logic                           wr_stage;
    logic                           wr_ptr;
    logic                           hit;

    // A write to the staged channel (now, or while it was loaded) makes the
    // staged value stale, so it must never produce an event.
    assign wr_stage = wr && (wr_ch == stage.ch);
    assign wr_ptr   = wr && (wr_ch == ptr);
    assign hit      = ena && stage.vld && wait_hit[stage.ch]
                      && (cnt >= stage.val) && !wr_stage;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign wr_sel[c]  = wr && (wr_ch == CW'(c));
        assign hit_sel[c] = hit && (stage.ch == CW'(c));

        compare_channel_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .srst     (srst),
            .wr_sel   (wr_sel[c]),
            .wr_arm   (wr_arm),
            .wr_val   (wr_val),
            .cnt      (cnt),
            .cnt_ovf  (cnt_ovf),
            .hit_sel  (hit_sel[c]),
            .val      (vals[c]),
            .armed    (armed[c]),
            .wait_hit (wait_hit[c])
        );
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr      <= '0;
            stage    <= '0;
            evt      <= '0;
            event_ch <= '0;
        end else begin
            if (ena) begin
                stage.vld <= !wr_ptr;
                stage.ch  <= ptr;
                stage.val <= vals[ptr];
                ptr       <= (ptr == CW'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
            end else if (wr_stage) begin
                // held stage is evaluated first on resume; drop it if stale
                stage.vld <= 1'b0;
            end
            evt <= hit_sel;            // all-zero when there is no hit
            if (hit)
                event_ch <= stage.ch;
        end
    end
endmodule

// File: tb/tb_compare_channel_scheduler.sv
module tb_compare_channel_scheduler;
    localparam int S_IDLE = 0;
    localparam int S_WRAP = 1;
    localparam int S_HIT  = 2;

    logic       clk = 1'b0;
    logic       srst, ena, cnt_ovf, wr, wr_arm;
    logic [7:0] cnt, wr_val;
    logic [1:0] wr_ch;
    logic [3:0] evt, armed;
    logic [1:0] event_ch;

    compare_channel_scheduler #(.WIDTH(8), .CHANNELS(4), .CW(2)) dut (
        .clk(clk), .srst(srst), .ena(ena), .cnt(cnt), .cnt_ovf(cnt_ovf),
        .wr(wr), .wr_ch(wr_ch), .wr_val(wr_val), .wr_arm(wr_arm),
        .evt(evt), .event_ch(event_ch), .armed(armed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // behavioural model
    int   m_st[4];
    int   m_val[4];
    int   m_ptr;
    bit   s_vld;
    int   s_ch, s_val;
    logic [3:0] m_evt;
    int   m_evch;

    // observation
    int ev_cnt[4];
    int ev_total;
    int last_cnt;
    logic [3:0] last_armed;
    int ev_log[$];
    int ev_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic logic [3:0] m_armed();
        logic [3:0] a;
        for (int c = 0; c < 4; c++) a[c] = (m_st[c] != S_IDLE);
        return a;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit hit;
        int hit_ch;
        if (srst) begin
            for (int c = 0; c < 4; c++) begin m_st[c] = S_IDLE; m_val[c] = 0; end
            m_ptr = 0; s_vld = 0; s_ch = 0; s_val = 0; m_evt = 0; m_evch = 0;
            return;
        end
        hit_ch = s_ch;
        hit = ena && s_vld && (m_st[s_ch] == S_HIT) && (int'(cnt) >= s_val)
              && !(wr && int'(wr_ch) == s_ch);
        if (ena) begin
            s_ch  = m_ptr;
            s_val = m_val[m_ptr];
            s_vld = !(wr && int'(wr_ch) == m_ptr);
            m_ptr = (m_ptr + 1) % 4;
        end else if (wr && int'(wr_ch) == s_ch) begin
            s_vld = 0;
        end
        for (int c = 0; c < 4; c++) begin
            if (wr && int'(wr_ch) == c) begin
                if (wr_arm) begin
                    m_val[c] = int'(wr_val);
                    m_st[c]  = (cnt >= wr_val) ? S_WRAP : S_HIT;
                end else begin
                    m_st[c] = S_IDLE;
                end
            end else if (cnt_ovf && m_st[c] == S_WRAP) begin
                m_st[c] = S_HIT;
            end else if (hit && c == hit_ch) begin
                m_st[c] = S_IDLE;
            end
        end
        m_evt = hit ? (4'b0001 << hit_ch) : 4'b0000;
        if (hit) m_evch = hit_ch;
    endtask

    // One clock: step model, let the DUT clock, compare on the falling edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        chk("event", evt, m_evt);
        chk("event_ch", event_ch, m_evch);
        chk("armed", armed, m_armed());
        chk("onehot", $onehot0(evt), 1);
        for (int c = 0; c < 4; c++) ev_cnt[c] += int'(evt[c]);
        ev_total += $countones(evt);
        if (evt != 0) begin
            last_cnt   = int'(cnt);
            last_armed = armed;
            ev_log.push_back(int'(event_ch));
            ev_cyc.push_back(cyc_n);
        end
        wr      = 1'b0;
        cnt_ovf = 1'b0;
    endtask

    task automatic clear_ev();
        for (int c = 0; c < 4; c++) ev_cnt[c] = 0;
        ev_total = 0;
        ev_log.delete();
        ev_cyc.delete();
    endtask

    task automatic write_ch(input int ch, input int v, input bit arm);
        wr = 1'b1; wr_ch = 2'(ch); wr_val = 8'(v); wr_arm = arm;
        cyc();
    endtask

    task automatic sweep(input int from, input int to);
        for (int v = from; v <= to; v++) begin
            cnt = 8'(v);
            cyc();
        end
    endtask

    task automatic wait_stage(input int ch);
        int g = 0;
        while (!(s_vld && s_ch == ch) && g < 8) begin cyc(); g++; end
        chk("stage_reach", g < 8, 1);
    endtask

    task automatic check_order(input string nm);
        chk({nm, "_count"}, ev_log.size(), 4);
        if (ev_log.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk({nm, "_order"}, ev_log[i+1], (ev_log[i] + 1) % 4);
            end
        end
        for (int c = 0; c < 4; c++) chk({nm, "_per_ch"}, ev_cnt[c], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
        $fatal(1);
    end

    initial begin
        int t20;
        int g;
        srst = 1; ena = 1; cnt = 0; cnt_ovf = 0;
        wr = 0; wr_ch = 0; wr_val = 0; wr_arm = 0;
        clear_ev();
        cyc(); cyc();
        chk("rst_armed", armed, 4'b0000);
        chk("rst_event", evt, 4'b0000);
        chk("rst_event_ch", event_ch, 0);

        // reset mid-scan with ch1 armed
        srst = 0; cnt = 10;
        write_ch(1, 50, 1);
        cyc(); cyc();
        chk("pre_rst_armed", armed, 4'b0010);
        srst = 1; cyc(); srst = 0;
        chk("mid_rst_armed", armed, 4'b0000);
        chk("mid_rst_event", evt, 4'b0000);
        clear_ev();
        sweep(10, 60);
        chk("rst_sweep_events", ev_total, 0);

        // basic hit: one step of cnt per 4 cycles
        cnt = 10;
        write_ch(2, 20, 1);
        clear_ev();
        t20 = 0;
        for (int v = 11; v <= 25; v++) begin
            cnt = 8'(v);
            if (v == 20) t20 = cyc_n;
            repeat (4) cyc();
        end
        chk("basic_total", ev_total, 1);
        chk("basic_ch2", ev_cnt[2], 1);
        chk("basic_event_ch", event_ch, 2);
        chk("basic_armed_clear", last_armed[2], 0);
        if (ev_cyc.size() > 0)
            chk("basic_latency", (ev_cyc[0] - t20 >= 1) && (ev_cyc[0] - t20 <= 5), 1);

        // wrap wait
        clear_ev();
        cnt = 200;
        write_ch(0, 50, 1);
        chk("wrap_armed", armed, 4'b0001);
        sweep(201, 255);
        chk("wrap_pre_ovf", ev_total, 0);
        cnt = 0; cnt_ovf = 1; cyc();
        sweep(1, 60);
        chk("wrap_total", ev_total, 1);
        chk("wrap_ch0", ev_cnt[0], 1);
        chk("wrap_window", (last_cnt >= 50) && (last_cnt <= 55), 1);

        // equality at arm means already passed
        clear_ev();
        cnt = 77;
        write_ch(3, 77, 1);
        chk("eq_armed", armed, 4'b1000);
        sweep(78, 255);
        chk("eq_pre_ovf", ev_total, 0);
        cnt = 0; cnt_ovf = 1; cyc();
        sweep(1, 90);
        chk("eq_ch3", ev_cnt[3], 1);
        chk("eq_window", (last_cnt >= 77) && (last_cnt <= 82), 1);

        // collision: disarm while ch1 hit is pending in the stage
        clear_ev();
        cnt = 10;
        write_ch(1, 20, 1);
        wait_stage(1);
        cnt = 30; wr = 1; wr_ch = 1; wr_val = 0; wr_arm = 0;
        cyc();
        repeat (6) cyc();
        chk("col_dis_events", ev_total, 0);
        chk("col_dis_armed", armed[1], 0);

        // collision: re-arm beyond cnt while ch1 hit is pending
        cnt = 10;
        write_ch(1, 20, 1);
        wait_stage(1);
        cnt = 30; wr = 1; wr_ch = 1; wr_val = 60; wr_arm = 1;
        cyc();
        repeat (6) cyc();
        chk("col_rearm_events", ev_total, 0);
        chk("col_rearm_armed", armed[1], 1);

        // multi-hit burst
        clear_ev();
        cnt = 0;
        for (int c = 0; c < 4; c++) write_ch(c, 5, 1);
        chk("multi_armed", armed, 4'b1111);
        cyc();
        cnt = 9;
        repeat (8) cyc();
        check_order("multi");
        if (ev_cyc.size() == 4)
            for (int i = 0; i < 3; i++) chk("multi_consec", ev_cyc[i+1] - ev_cyc[i], 1);
        chk("multi_armed_after", armed, 4'b0000);

        // burst interrupted by ena low
        clear_ev();
        cnt = 0;
        for (int c = 0; c < 4; c++) write_ch(c, 5, 1);
        cyc();
        cnt = 9;
        g = 0;
        while (ev_total < 2 && g < 10) begin cyc(); g++; end
        chk("ena_first_two", ev_total, 2);
        ena = 0;
        repeat (3) begin
            cyc();
            chk("ena_low_event", evt, 4'b0000);
        end
        chk("ena_low_armed", $countones(armed), 2);
        ena = 1;
        repeat (6) cyc();
        check_order("ena");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
